// File: rtl/march_bist_ctrl.sv
// March C- memory BIST controller: drives a synchronous-write, two-cycle-latency-read memory port.
// Optional build macro BIST_STOP_ON_FAIL_EN ends the run at the first read mismatch.
module march_bist_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [15:0]           fail_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_ISSUE = 3'd2,
        R_ISSUE = 3'd3,
        R_WAIT  = 3'd4,
        R_CMP   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [2:0]            LAST_ELEM = 3'd5;
    localparam logic [DATA_WIDTH-1:0] ALL_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONE   = {DATA_WIDTH{1'b1}};

    // Elements E3 and E4 sweep from the top address down.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // E0 (w0) and E5 (r0) hold one op per address; the others hold read-then-write.
    function automatic logic elem_single_op(input logic [2:0] e);
        return (e == 3'd0) || (e == 3'd5);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] write_pattern(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? ALL_ONE : ALL_ZERO;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_pattern(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? ALL_ONE : ALL_ZERO;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return elem_down(e) ? LAST_ADDR : ADDR_ZERO;
    endfunction

    state_t                  state_r;
    logic [2:0]              elem_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    op_r;
    logic                    write_read_r;
    logic [ADDR_WIDTH-1:0]   address_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    fail_r;
    logic [ADDR_WIDTH-1:0]   fail_addr_r;
    logic [2:0]              fail_elem_r;
    logic [15:0]             fail_count_r;

    logic                    last_op_s;
    logic                    last_addr_s;
    logic [2:0]              nxt_elem_s;
    logic [ADDR_WIDTH-1:0]   nxt_addr_s;
    logic                    nxt_op_s;
    logic                    nxt_write_s;
    logic                    run_end_s;
    logic                    mismatch_s;
    logic                    stop_now_s;

    // Next-op sequencer: second op of the address, next address, next element, or end of run.
    always_comb begin
        last_op_s   = elem_single_op(elem_r) ? 1'b1 : op_r;
        last_addr_s = elem_down(elem_r) ? (addr_r == ADDR_ZERO) : (addr_r == LAST_ADDR);
        nxt_elem_s  = elem_r;
        nxt_addr_s  = addr_r;
        nxt_op_s    = 1'b0;
        run_end_s   = 1'b0;
        if (!last_op_s) begin
            nxt_op_s = 1'b1;
        end else if (!last_addr_s) begin
            nxt_addr_s = elem_down(elem_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end else if (elem_r == LAST_ELEM) begin
            run_end_s = 1'b1;
        end else begin
            nxt_elem_s = elem_r + 3'd1;
            nxt_addr_s = first_addr(elem_r + 3'd1);
        end
        // Every op of E0 is a write; elsewhere the write is always the second op.
        nxt_write_s = (nxt_elem_s == 3'd0) || nxt_op_s;
    end

    // Read comparison and the optional early-exit decision.
    always_comb begin
        mismatch_s = (rdata != read_pattern(elem_r));
`ifdef BIST_STOP_ON_FAIL_EN
        stop_now_s = (state_r == R_CMP) && mismatch_s;
`else
        stop_now_s = 1'b0;
`endif
    end

    // Controller FSM with registered memory strobes and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            elem_r       <= 3'd0;
            addr_r       <= ADDR_ZERO;
            op_r         <= 1'b0;
            write_read_r <= 1'b0;
            address_r    <= ADDR_ZERO;
            wdata_r      <= ALL_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
            fail_addr_r  <= ADDR_ZERO;
            fail_elem_r  <= 3'd0;
            fail_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    write_read_r <= 1'b0;
                    if (start) begin
                        state_r      <= W_SETUP;
                        elem_r       <= 3'd0;
                        addr_r       <= ADDR_ZERO;
                        op_r         <= 1'b0;
                        address_r    <= ADDR_ZERO;
                        wdata_r      <= write_pattern(3'd0);
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        fail_r       <= 1'b0;
                        fail_addr_r  <= ADDR_ZERO;
                        fail_elem_r  <= 3'd0;
                        fail_count_r <= 16'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                W_SETUP: begin
                    write_read_r <= 1'b1;
                    state_r      <= W_ISSUE;
                end
                R_ISSUE: begin
                    write_read_r <= 1'b0;
                    state_r      <= R_WAIT;
                end
                R_WAIT: begin
                    write_read_r <= 1'b0;
                    state_r      <= R_CMP;
                end
                W_ISSUE, R_CMP: begin
                    write_read_r <= 1'b0;
                    if ((state_r == R_CMP) && mismatch_s) begin
                        fail_r <= 1'b1;
                        if (fail_count_r != 16'hFFFF) begin
                            fail_count_r <= fail_count_r + 16'd1;
                        end else begin
                            fail_count_r <= fail_count_r;
                        end
                        // Only the first mismatch of a run is located.
                        if (!fail_r) begin
                            fail_addr_r <= addr_r;
                            fail_elem_r <= elem_r;
                        end else begin
                            fail_addr_r <= fail_addr_r;
                            fail_elem_r <= fail_elem_r;
                        end
                    end else begin
                        fail_r <= fail_r;
                    end
                    if (stop_now_s || run_end_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        elem_r    <= nxt_elem_s;
                        addr_r    <= nxt_addr_s;
                        op_r      <= nxt_op_s;
                        address_r <= nxt_addr_s;
                        if (nxt_write_s) begin
                            state_r <= W_SETUP;
                            wdata_r <= write_pattern(nxt_elem_s);
                        end else begin
                            state_r <= R_ISSUE;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    write_read_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign write_read = write_read_r;
    assign address    = address_r;
    assign wdata      = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fail       = fail_r;
    assign fail_addr  = fail_addr_r;
    assign fail_elem  = fail_elem_r;
    assign fail_count = fail_count_r;

endmodule

// File: doc/march_bist_ctrl.md
MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have parameter CAPACITY, default 16, number of words tested (addresses 0..CAPACITY-1), CAPACITY <= 2**ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  begin a test run when idle.
REQ-007 SHALL have port write_read  output  1  memory strobe: 1 = write, 0 = read.
REQ-008 SHALL have port address  output  ADDR_WIDTH  memory address.
REQ-009 SHALL have port wdata  output  DATA_WIDTH  memory write data.
REQ-010 SHALL have port rdata  input  DATA_WIDTH  memory read data.
REQ-011 SHALL have port busy  output  1  test run in progress.
REQ-012 SHALL have port done  output  1  run finished; held until next accepted start.
REQ-013 SHALL have port fail  output  1  sticky: at least one mismatch this run.
REQ-014 SHALL have port fail_addr  output  ADDR_WIDTH  address of first mismatch.
REQ-015 SHALL have port fail_elem  output  3  March element index (0..5) of first mismatch.
REQ-016 SHALL have port fail_count  output  16  number of mismatching reads, saturating at 16'hFFFF.

Function
REQ-017 SHALL execute March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0); "0" = all-zero word, "1" = all-one word.
REQ-018 SHALL sweep up elements from address 0 to CAPACITY-1, down elements from CAPACITY-1 to 0; the element ends after the last address's final op with no wrap-around.
REQ-019 SHALL perform each write in two cycles: W_SETUP (write_read=0, address=target, wdata=pattern), then W_ISSUE (write_read=1, same address, wdata held), since the memory captures wdata one cycle before committing.
REQ-020 SHALL perform each read in three cycles: R_ISSUE (write_read=0, address=target), R_WAIT, R_CMP; rdata is compared against the expected pattern in R_CMP (two-edge memory read latency).
REQ-021 SHALL hold write_read=0 in every state other than W_ISSUE.
REQ-022 SHALL use FSM states IDLE, W_SETUP, W_ISSUE, R_ISSUE, R_WAIT, R_CMP, DONE; op sequencing and address stepping are decided at the end of W_ISSUE / R_CMP.
REQ-023 SHALL accept start only in IDLE or DONE; accepting clears done, fail, fail_addr, fail_elem, fail_count and sets busy the following cycle; start while busy is ignored.
REQ-024 SHALL, on a mismatch, set fail, increment fail_count, and load fail_addr/fail_elem only if fail was 0 before that cycle.
REQ-025 SHALL complete a fault-free run in exactly 25*CAPACITY cycles of busy, then assert done with busy=0 in the next cycle.
REQ-026 SHALL keep busy and done mutually exclusive.

Reset
REQ-027 SHALL, with rst=1 at a rising edge, enter IDLE and drive write_read=0, address=0, wdata=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_count=0 after that edge.
REQ-028 SHALL abort a run on mid-operation reset with no further write strobe issued after the reset edge; rst has priority over start.

Configuration
REQ-029 SHALL, with macro BIST_STOP_ON_FAIL_EN defined, go from R_CMP directly to DONE on the first mismatch (fail_count=1).
REQ-030 SHALL, without BIST_STOP_ON_FAIL_EN, run all six elements regardless of mismatches, counting each one.

Verification
REQ-031 SHALL cover: fault-free 16-word model, pulse start -> done after 400 busy cycles, fail=0, fail_count=0.
REQ-032 SHALL cover: address 3 bit0 stuck-at-1, macro off -> fail=1, fail_addr=3, fail_elem=1, fail_count=3 (E1, E3, E5 r0 reads).
REQ-033 SHALL cover: same fault, macro on -> done right after the E1 read of address 3, fail_count=1, fail_elem=1.
REQ-034 SHALL cover: rst asserted in the middle of E3 -> next cycle IDLE, all outputs 0, no write_read=1 after reset edge; a new start then runs to a clean pass.
REQ-035 SHALL cover: start pulsed while busy -> ignored, run length unchanged; a check that wdata equals the target pattern in both W_SETUP and W_ISSUE on every write.
